// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with push, pop, flush and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !flush_i;

  // Flush keeps the read pointer so the head register holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= rptr_q;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, buffered handoff to decode
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect emits a fault entry and parks in FAULT.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            srst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            pop, push, gnt_fire, misalign;
  fetch_entry_t    push_entry, head;

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid && id_ready;
  assign gnt_fire = imem_req && imem_gnt;
  assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
  logic            fault_pend_q;
  logic [XLEN-1:0] fault_pc_q;

  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      fault_pend_q <= misalign;
      if (misalign) fault_pc_q <= redirect_pc;
    end
  end

  // No request is ever granted in a redirect cycle, so the fault push cannot meet a response.
  assign push       = fault_pend_q || (imem_rvalid && !redirect_valid);
  assign push_entry = fault_pend_q ? fetch_entry_t'{instr: NOP_INSTR,  pc: fault_pc_q, fault: 1'b1}
                                   : fetch_entry_t'{instr: imem_rdata, pc: req_pc_q,   fault: 1'b0};
  assign id_fault   = head.fault;
`else
  logic unused_bits;

  assign misalign    = 1'b0;
  assign push        = imem_rvalid && !redirect_valid;
  assign push_entry  = fetch_entry_t'{instr: imem_rdata, pc: req_pc_q, fault: 1'b0};
  assign id_fault    = 1'b0;
  assign unused_bits = ^{head.fault, redirect_pc[1:0]};
`endif

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) state_q <= BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = misalign ? FAULT : RUN;
      RUN:     if (misalign) state_d = FAULT;
      FAULT:   if (redirect_valid && !misalign) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Occupancy counts the response still in flight so the buffer can never overflow.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_comb begin
    imem_req = 1'b0;
    if (state_q == RUN && !redirect_valid && occupancy < (CW+1)'(FIFO_DEPTH))
      imem_req = 1'b1;
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
    end else if (gnt_fire) begin
      pc_d       = pc_q + XLEN'(4);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end else if (imem_rvalid) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (srst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign id_instr = head.instr;
  assign id_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (table vectors, directed corners, random vs model)
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid;
  logic        id_valid, id_ready, id_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .srst_n(srst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_fault(id_fault)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: decode sees the program-order stream from the last restart point, each
  // entry visible two cycles after its grant; at most DEPTH fetches outstanding.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int          vis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fetch_pc;
  int          cyc;
  logic        faulted;
  int          grants;
  logic [31:0] popped[$];
  logic        s_req, s_vld, s_fault;
  logic [31:0] s_addr, s_pc, s_instr;

  typedef struct {
    logic        gnt, rdy, rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0F0F;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    srst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 srst_n = 1'b1;
    exp_q.delete(); fetch_pc = RST_PC; cyc = 0; faulted = 1'b0;
  endtask

  // One cycle: sample and check at negedge, update model, answer memory after posedge.
  task automatic step();
    logic        e_vld, e_req, pop, fire;
    logic [31:0] a_s;
    @(negedge clk);
    e_vld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    pop   = e_vld && id_ready;
    e_req = (cyc >= 1) && !faulted && !redirect_valid &&
            ((exp_q.size() - (pop ? 1 : 0)) < DEPTH);
    chk1("imem_req", imem_req, e_req);
    if (e_req) chk32("imem_addr", imem_addr, fetch_pc);
    chk1("id_valid", id_valid, e_vld);
    if (e_vld) begin
      chk32("id_pc", id_pc, exp_q[0].pc);
      chk32("id_instr", id_instr, exp_q[0].instr);
      chk1("id_fault", id_fault, exp_q[0].fault);
    end
    s_req = imem_req; s_addr = imem_addr; s_vld = id_valid;
    s_pc = id_pc; s_instr = id_instr; s_fault = id_fault;
    fire = imem_req && imem_gnt;
    a_s  = imem_addr;
    if (fire) grants++;
    if (id_valid && id_ready) popped.push_back(id_pc);
    if (pop) void'(exp_q.pop_front());
    if (e_req && imem_gnt) begin
      exp_q.push_back('{fetch_pc, mem_word(fetch_pc), 1'b0, cyc + 2});
      fetch_pc += 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        exp_q.push_back('{redirect_pc, NOP_INSTR, 1'b1, cyc + 2});
        faulted = 1'b1;
      end else begin
        faulted = 1'b0;
      end
`endif
      fetch_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    imem_rvalid = fire;
    imem_rdata  = fire ? mem_word(a_s) : $urandom();
    cyc++;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h8};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};

    // Startup stream, gnt stall at 0x8, redirect colliding with the 0xC response.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      imem_gnt = tbl[i].gnt; id_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rdr; redirect_pc = tbl[i].rpc;
      step();
      chk1($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
      if (tbl[i].e_req) chk32($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      chk1($sformatf("tbl%0d_vld", i), s_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk32($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end
    redirect_valid = 1'b0;

    // Decode stalled: exactly DEPTH grants, then ordered drain.
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0; grants = 0;
    repeat (10) step();
    chk32("stall_grants", 32'(grants), 32'(DEPTH));
    chk1("stall_req_off", s_req, 1'b0);
    id_ready = 1'b1; popped.delete();
    repeat (8) step();
    chk32("drain_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++)
      chk32($sformatf("drain_pc%0d", i), popped[i], 32'(i * 4));

    // Asynchronous reset with the buffer full.
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    repeat (6) step();
    chk1("full_before_rst", s_vld, 1'b1);
    #3 srst_n = 1'b0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk32("rst_id_instr", id_instr, 32'h0);
    chk32("rst_id_pc", id_pc, 32'h0);
    chk1("rst_id_fault", id_fault, 1'b0);
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1;
    step();
    chk1("boot_no_req", s_req, 1'b0);
    step();
    chk1("refetch_req", s_req, 1'b1);
    chk32("refetch_addr", s_addr, RST_PC);

    // Misaligned redirect target.
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    step();
    chk1("flt_req_off", s_req, 1'b0);
    step();
    chk1("flt_vld", s_vld, 1'b1);
    chk32("flt_pc", s_pc, 32'h102);
    chk32("flt_instr", s_instr, NOP_INSTR);
    chk1("flt_fault", s_fault, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("flt_parked%0d", i), s_req, 1'b0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    step();
    chk1("resume_req", s_req, 1'b1);
    chk32("resume_addr", s_addr, 32'h200);
`else
    step();
    chk1("mis_req", s_req, 1'b1);
    chk32("mis_addr", s_addr, 32'h100);
    step();
    step();
    chk1("mis_vld", s_vld, 1'b1);
    chk32("mis_pc", s_pc, 32'h100);
    chk1("mis_fault", s_fault, 1'b0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      imem_gnt       = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = 32'hFFFF_FFF4;
        1:       redirect_pc = (32'($urandom_range(0, 1023)) << 2) | 32'd1;
        default: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
      step();
    end
    redirect_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
